store_split_seq: RTL and testbench

STORE_SPLIT_SEQ -- requirements
Module: store_split_seq

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/store_align.sv | 58 +++++
 rtl/store_split_seq.sv | 129 ++++++++++++
 tb/tb_store_split_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the store path: the sequencer state encoding and
// the funct3 store-width codes.
// ---------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } seqState_t;

   localparam logic [1:0] F3_SB = 2'd0;
   localparam logic [1:0] F3_SH = 2'd1;
   localparam logic [1:0] F3_SW = 2'd2;

   // Only byte, half and word stores exist; code 3 is reported as an error.
   function automatic logic isLegalWidth(input logic [1:0] width);
      return (width != 2'd3);
   endfunction

endpackage

// File: rtl/store_align.sv
// ---------------------------------------------------------------------------
// store_align
// Combinational lane aligner. Places a right-justified store operand on its
// byte lanes across a two-word (64-bit) window starting at the word that
// holds the first byte.
//   funct3  in  3   store width (bit 2 is don't-care)
//   off     in  2   byte offset within the first word
//   data    in  32  right-justified store data
//   mask8   out 8   byte enables over the two-word window
//   data64  out 64  lane-aligned data over the two-word window
// An illegal width produces an empty mask and zero data.
// ---------------------------------------------------------------------------
module store_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] data,
   output logic [7:0]  mask8,
   output logic [63:0] data64
);

   logic [3:0]  baseMask;
   logic [31:0] extData;
   logic [63:0] extData64;
   logic        unusedBits;

   // Width is selected by the low two bits only.
   assign unusedBits = funct3[2];

   always_comb begin
      baseMask = 4'b0000;
      extData  = 32'd0;
      unique case (funct3[1:0])
         F3_SB: begin
            baseMask = 4'b0001;
            extData  = {24'd0, data[7:0]};
         end
         F3_SH: begin
            baseMask = 4'b0011;
            extData  = {16'd0, data[15:0]};
         end
         F3_SW: begin
            baseMask = 4'b1111;
            extData  = data;
         end
         default: begin
            baseMask = 4'b0000;
            extData  = 32'd0;
         end
      endcase
   end

   assign extData64 = {32'd0, extData};
   assign mask8     = {4'd0, baseMask} << off;
   assign data64    = extData64 << {off, 3'b000};

endmodule

// File: rtl/store_split_seq.sv
// ---------------------------------------------------------------------------
// store_split_seq
// Turns one store request of any alignment into one or two word-aligned
// memory write beats. A store whose bytes cross a word boundary is split
// into BEAT0 (lower word) and BEAT1 (next word, address wraps mod 2^32).
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_funct3, req_addr, req_data   store width, byte address, data
//   mem_valid/mem_ready              write-beat handshake
//   mem_addr, mem_wmask, mem_wdata   beat address, byte enables, lane data
//   done                             one-cycle pulse after the final beat
//   err                              one-cycle pulse after an illegal width
//   busy                             high while a store is in flight
// ---------------------------------------------------------------------------
module store_split_seq
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   output logic        done,
   output logic        err,
   output logic        busy
);

   seqState_t   stateReg, stateNext;
   logic [29:0] wordAddrReg;
   logic [7:0]  mask8Reg;
   logic [63:0] data64Reg;
   logic        doneReg, errReg;
   logic        doneNext;

   logic [7:0]  alignMask8;
   logic [63:0] alignData64;
   logic        accept, legal;

   store_align uAlign (
      .funct3 (req_funct3),
      .off    (req_addr[1:0]),
      .data   (req_data),
      .mask8  (alignMask8),
      .data64 (alignData64)
   );

   assign accept = req_valid && (stateReg == IDLE);
   assign legal  = isLegalWidth(req_funct3[1:0]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateReg    <= IDLE;
         wordAddrReg <= 30'd0;
         mask8Reg    <= 8'd0;
         data64Reg   <= 64'd0;
         doneReg     <= 1'b0;
         errReg      <= 1'b0;
      end else begin
         stateReg <= stateNext;
         doneReg  <= doneNext;
         errReg   <= accept && !legal;
         // Illegal requests are consumed without touching the beat fields.
         if (accept && legal) begin
            wordAddrReg <= req_addr[31:2];
            mask8Reg    <= alignMask8;
            data64Reg   <= alignData64;
         end
      end
   end

   // Beat outputs come straight from the held registers, so they stay
   // stable for as long as the memory stalls.
   always_comb begin
      stateNext = stateReg;
      doneNext  = 1'b0;
      req_ready = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = 32'd0;
      mem_wmask = 4'd0;
      mem_wdata = 32'd0;
      unique case (stateReg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && legal) begin
               stateNext = BEAT0;
            end
         end
         BEAT0: begin
            mem_valid = 1'b1;
            mem_addr  = {wordAddrReg, 2'b00};
            mem_wmask = mask8Reg[3:0];
            mem_wdata = data64Reg[31:0];
            if (mem_ready) begin
               if (mask8Reg[7:4] != 4'd0) begin
                  stateNext = BEAT1;
               end else begin
                  stateNext = IDLE;
                  doneNext  = 1'b1;
               end
            end
         end
         BEAT1: begin
            mem_valid = 1'b1;
            mem_addr  = {wordAddrReg + 30'd1, 2'b00};
            mem_wmask = mask8Reg[7:4];
            mem_wdata = data64Reg[63:32];
            if (mem_ready) begin
               stateNext = IDLE;
               doneNext  = 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign done = doneReg;
   assign err  = errReg;
   assign busy = (stateReg != IDLE);

endmodule

// File: tb/tb_store_split_seq.sv
// ---------------------------------------------------------------------------
// tb_store_split_seq
// Self-checking bench. A byte-level model turns each accepted store into the
// list of word beats it must produce; a negedge compare process checks every
// output on every cycle. Directed cases pin literal expectations.
// ---------------------------------------------------------------------------
module tb_store_split_seq;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic        done;
   logic        err;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   store_split_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wmask  (mem_wmask),
      .mem_wdata  (mem_wdata),
      .done       (done),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   beat_t expBeats[$];
   logic  expDone = 1'b0;
   logic  expErr  = 1'b0;
   logic  started = 1'b0;
   logic  postReset = 1'b0;

   // Observation log read by the directed cases.
   beat_t obsLog[$];
   int    cycle = 0;
   int    acceptCycle = 0;
   int    evtCount = 0;
   int    evtCycle = 0;
   logic  evtWasErr = 1'b0;

   // Scatter each byte of the store to its own address and group by word.
   function automatic void modelAccept(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int          n;
      beat_t       b0, b1;
      logic        have1;
      logic [31:0] ba;
      n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      b0 = '{addr: {a[31:2], 2'b00}, mask: 4'd0, data: 32'd0};
      b1 = '{addr: {a[31:2], 2'b00} + 32'd4, mask: 4'd0, data: 32'd0};
      have1 = 1'b0;
      for (int i = 0; i < n; i++) begin
         ba = a + 32'(i);
         if (ba[31:2] == a[31:2]) begin
            b0.mask[ba[1:0]] = 1'b1;
            b0.data[8*ba[1:0] +: 8] = d[8*i +: 8];
         end else begin
            have1 = 1'b1;
            b1.mask[ba[1:0]] = 1'b1;
            b1.data[8*ba[1:0] +: 8] = d[8*i +: 8];
         end
      end
      expBeats.push_back(b0);
      if (have1) expBeats.push_back(b1);
   endfunction

   always @(negedge clk) begin
      logic idleNow;
      cycle++;
      idleNow = (expBeats.size() == 0);
      if (started) begin
         chk("req_ready", req_ready, idleNow);
         chk("busy", busy, !idleNow);
         chk("mem_valid", mem_valid, !idleNow);
         chk("done", done, expDone);
         chk("err", err, expErr);
         if (!idleNow) begin
            chk("mem_addr", mem_addr, expBeats[0].addr);
            chk("mem_wmask", mem_wmask, expBeats[0].mask);
            chk("mem_wdata", mem_wdata, expBeats[0].data);
         end else begin
            chk("idle_wmask", mem_wmask, 4'd0);
         end
         if (postReset) begin
            chk("rst_addr", mem_addr, 32'd0);
            chk("rst_wdata", mem_wdata, 32'd0);
         end
         if (done || err) begin
            evtCount++;
            evtCycle  = cycle;
            evtWasErr = err;
         end
      end
      // Predict what the next clock edge does.
      if (!rst_n) begin
         expBeats.delete();
         expDone   = 1'b0;
         expErr    = 1'b0;
         started   = 1'b1;
         postReset = 1'b1;
      end else if (started) begin
         expDone = 1'b0;
         expErr  = 1'b0;
         if (!idleNow && mem_valid && mem_ready) begin
            obsLog.push_back('{addr: mem_addr, mask: mem_wmask, data: mem_wdata});
            if (expBeats.size() == 1) expDone = 1'b1;
            void'(expBeats.pop_front());
         end
         if (idleNow && req_valid) begin
            acceptCycle = cycle;
            postReset   = 1'b0;
            if (req_funct3[1:0] == 2'd3) expErr = 1'b1;
            else modelAccept(req_funct3, req_addr, req_data);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic randReady = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (randReady) mem_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic directed(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int stall, input int nBeats,
                           input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] w0,
                           input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] w1,
                           input int lat, input logic isErr);
      int   base, evt0;
      logic acc, got;
      base = obsLog.size();
      evt0 = evtCount;
      mem_ready  = (stall == 0);
      req_valid  = 1'b1;
      req_funct3 = f3;
      req_addr   = a;
      req_data   = d;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         acc = req_ready;
         tick();
         if (acc) begin got = 1'b1; break; end
      end
      chk({nm, " accept"}, got, 1'b1);
      req_valid = 1'b0;
      for (int s = 0; s < stall; s++) tick();
      mem_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (evtCount != evt0) begin got = 1'b1; break; end
         tick();
      end
      chk({nm, " finish"}, got, 1'b1);
      chk({nm, " beats"}, obsLog.size() - base, nBeats);
      if (nBeats > 0 && obsLog.size() > base) begin
         chk({nm, " b0addr"}, obsLog[base].addr, a0);
         chk({nm, " b0mask"}, obsLog[base].mask, m0);
         chk({nm, " b0data"}, obsLog[base].data, w0);
      end
      if (nBeats > 1 && obsLog.size() > base + 1) begin
         chk({nm, " b1addr"}, obsLog[base+1].addr, a1);
         chk({nm, " b1mask"}, obsLog[base+1].mask, m1);
         chk({nm, " b1data"}, obsLog[base+1].data, w1);
      end
      chk({nm, " latency"}, evtCycle - acceptCycle, lat);
      chk({nm, " kind"}, evtWasErr, isErr);
      $display("case %s: beats=%0d latency=%0d", nm, obsLog.size() - base, evtCycle - acceptCycle);
   endtask

   initial begin
      int   evt0, nTx;
      logic acc, got;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_data   = 32'd0;
      mem_ready  = 1'b1;
      tick();
      tick();
      chk("reset req_ready", req_ready, 1'b1);
      chk("reset busy", busy, 1'b0);
      chk("reset mem_valid", mem_valid, 1'b0);
      chk("reset done", done, 1'b0);
      rst_n = 1'b1;
      tick();

      directed("sw_aligned", 3'd2, 32'h100, 32'hDEADBEEF, 0, 1,
               32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 2, 1'b0);
      directed("sh_split", 3'd1, 32'h203, 32'h0000ABCD, 0, 2,
               32'h200, 4'b1000, 32'hCD000000, 32'h204, 4'b0001, 32'h000000AB, 3, 1'b0);
      directed("sb_stall", 3'd0, 32'h006, 32'h12345678, 3, 1,
               32'h004, 4'b0100, 32'h00780000, 32'h0, 4'h0, 32'h0, 5, 1'b0);
      directed("sw_wrap", 3'd2, 32'hFFFFFFFE, 32'h11223344, 0, 2,
               32'hFFFFFFFC, 4'b1100, 32'h33440000, 32'h0, 4'b0011, 32'h00001122, 3, 1'b0);
      directed("illegal", 3'd3, 32'h40, 32'h1, 0, 0,
               32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1, 1'b1);
      directed("sh_f3bit2", 3'd5, 32'h011, 32'h0000BEEF, 0, 1,
               32'h010, 4'b0110, 32'h00BEEF00, 32'h0, 4'h0, 32'h0, 2, 1'b0);

      // Reset while the second beat of a split store is pending.
      evt0 = evtCount;
      mem_ready  = 1'b0;
      req_valid  = 1'b1;
      req_funct3 = 3'd1;
      req_addr   = 32'h203;
      req_data   = 32'h0000ABCD;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         acc = req_ready;
         tick();
         if (acc) begin got = 1'b1; break; end
      end
      chk("rst_mid accept", got, 1'b1);
      req_valid = 1'b0;
      mem_ready = 1'b1;
      tick();                          // BEAT0 handshake
      chk("rst_mid in_beat1 addr", mem_addr, 32'h204);
      rst_n = 1'b0;
      tick();
      chk("rst_mid mem_valid", mem_valid, 1'b0);
      chk("rst_mid busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();
      tick();
      chk("rst_mid no_done", evtCount - evt0, 0);
      $display("case rst_mid: events=%0d", evtCount - evt0);

      // Randomized traffic with random memory stalls and occasional resets.
      randReady = 1'b1;
      nTx = 0;
      for (int c = 0; c < 4000; c++) begin
         acc = req_valid && req_ready && rst_n;
         if (acc) nTx++;
         tick();
         if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
         if (acc || !req_valid) begin
            req_valid  = ($urandom_range(0, 2) != 0);
            req_funct3 = 3'($urandom_range(0, 7));
            req_data   = $urandom;
            if ($urandom_range(0, 4) == 0) req_addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else req_addr = $urandom;
         end
      end
      $display("random phase: accepted=%0d", nTx);
      req_valid = 1'b0;
      rst_n     = 1'b1;
      for (int k = 0; k < 20; k++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
